// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Memory/IO side bus of the memory-stage access controller.
//   master (controller): drives mem_addr, mem_wdata, dmem_we, imem_we,
//                        io_valid, io_we; samples dmem_rdata, io_ready, io_rdata
//   slave  (memories/IO): the mirror image of master
// mem_addr and mem_wdata are shared by dmem, imem and the IO port.
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int XLEN = 32
) ();
  localparam int NLANES = XLEN / 8;

  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NLANES-1:0] dmem_we;
  logic [NLANES-1:0] imem_we;
  logic [XLEN-1:0]   dmem_rdata;
  logic              io_valid;
  logic [NLANES-1:0] io_we;
  logic              io_ready;
  logic [XLEN-1:0]   io_rdata;

  modport master (
    output mem_addr, mem_wdata, dmem_we, imem_we, io_valid, io_we,
    input  dmem_rdata, io_ready, io_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, dmem_we, imem_we, io_valid, io_we,
    output dmem_rdata, io_ready, io_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Memory-stage access controller: region decode (dmem / imem / IO), lane write
// enables and lane-shifted store data, load extraction and extension, two-beat
// handling of word-crossing accesses and an IO valid/ready handshake with
// timeout.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid, opcode, funct3   memory-stage request and its decode fields
//   addr, wdata                 byte address, right-justified store data
//   req_ready                   1 = access completes this cycle (0 stalls)
//   bus                         memory/IO bus (master modport)
//   load_data, load_valid       load result, one cycle after completion
//   misalign_fault, io_timeout  one-cycle event pulses
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int XLEN             = 32,
  parameter int ALLOW_MISALIGNED = 1,
  parameter int IO_WAIT_MAX      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              req_ready,
  mem_access_ctrl_if.master bus,
  output logic [XLEN-1:0]   load_data,
  output logic              load_valid,
  output logic              misalign_fault,
  output logic              io_timeout
);
  localparam int NLANES = XLEN / 8;
  localparam int OFFW   = $clog2(NLANES);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {ST_IDLE, ST_SPLIT, ST_IO_WAIT} state_t;
  // Where the registered load result takes its bytes from.
  typedef enum logic [1:0] {SRC_ZERO, SRC_DMEM, SRC_IO, SRC_SPLIT} src_t;

  state_t state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;

  logic            load_valid_reg, lv_next;
  logic            fault_reg, fault_next;
  logic            timeout_reg, timeout_next;
  src_t            ld_src_reg, src_next;
  logic [OFFW-1:0] ld_off_reg;
  logic [3:0]      ld_nbytes_reg;
  logic            ld_zext_reg;
  logic [XLEN-1:0] io_cap_reg;
  logic [XLEN-1:0] hold_reg;
  logic            io_cap_en, hold_en;

  // ---------------------------------------------------------------- decode
  logic is_load, is_store, is_access;
  logic io_hit, dm_hit, im_hit;

  assign is_load   = req_valid && (opcode == OP_LOAD);
  assign is_store  = req_valid && (opcode == OP_STORE);
  assign is_access = is_load || is_store;

  assign io_hit = (addr[31:28] == 4'b1000);
  assign dm_hit = !addr[31] && addr[28];
  assign im_hit = !addr[31] && addr[29] && is_store;

  // 8-byte accesses degrade to 4-byte ones on a 32-bit datapath.
  logic [1:0] size_code;
  logic [3:0] nbytes;
  assign size_code = (funct3[1:0] == 2'b11 && XLEN == 32) ? 2'b10 : funct3[1:0];
  assign nbytes    = 4'd1 << size_code;

  logic [OFFW-1:0] off;
  logic            crosses;
  assign off     = addr[OFFW-1:0];
  assign crosses = (5'(off) + 5'(nbytes)) > 5'(NLANES);

  logic [NLANES-1:0] size_mask;
  generate
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_size_mask
      assign size_mask[gi] = (5'(gi) < {1'b0, nbytes});
    end
  endgenerate

  // Double-width views: the low half is beat 0 (or the whole aligned
  // access), the high half is what spills into the next word for beat 1.
  logic [2*NLANES-1:0] lane_full;
  logic [2*XLEN-1:0]   wdata_full;
  logic [XLEN-1:0]     addr_aligned, addr_next_word;
  assign lane_full      = {{NLANES{1'b0}}, size_mask} << off;
  assign wdata_full     = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  assign addr_aligned   = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign addr_next_word = addr_aligned + XLEN'(NLANES);

  // The first IO cycle happens in IDLE and counts as wait cycle 0.
  logic io_expire;
  assign io_expire = (((state_reg == ST_IO_WAIT) ? cnt_reg : 8'd0) == 8'(IO_WAIT_MAX - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    req_ready     = 1'b1;
    bus.mem_addr  = addr_aligned;
    bus.mem_wdata = wdata_full[XLEN-1:0];
    bus.dmem_we   = '0;
    bus.imem_we   = '0;
    bus.io_valid  = 1'b0;
    bus.io_we     = '0;
    lv_next       = 1'b0;
    src_next      = SRC_ZERO;
    fault_next    = 1'b0;
    timeout_next  = 1'b0;
    io_cap_en     = 1'b0;
    hold_en       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (is_access) begin
          if (crosses && (ALLOW_MISALIGNED == 0 || io_hit)) begin
            fault_next = 1'b1;
          end else if (io_hit) begin
            bus.io_valid = 1'b1;
            bus.io_we    = is_store ? lane_full[NLANES-1:0] : '0;
            if (bus.io_ready) begin
              lv_next   = is_load;
              src_next  = SRC_IO;
              io_cap_en = 1'b1;
            end else if (io_expire) begin
              timeout_next = 1'b1;
              lv_next      = is_load;
            end else begin
              req_ready  = 1'b0;
              state_next = ST_IO_WAIT;
              cnt_next   = 8'd1;
            end
          end else if (crosses && (dm_hit || im_hit)) begin
            // Beat 0: upper lanes of the aligned word.
            bus.dmem_we = (is_store && dm_hit) ? lane_full[NLANES-1:0] : '0;
            bus.imem_we = im_hit ? lane_full[NLANES-1:0] : '0;
            req_ready   = 1'b0;
            state_next  = ST_SPLIT;
          end else begin
            // Aligned access, or an unmapped one (store dropped, load = 0).
            bus.dmem_we = (is_store && dm_hit) ? lane_full[NLANES-1:0] : '0;
            bus.imem_we = im_hit ? lane_full[NLANES-1:0] : '0;
            lv_next     = is_load;
            src_next    = dm_hit ? SRC_DMEM : SRC_ZERO;
          end
        end
      end

      ST_SPLIT: begin
        // Beat 1: low lanes of the following word. dmem_rdata now carries
        // the beat-0 word, which is parked in hold_reg for the merge.
        bus.mem_addr  = addr_next_word;
        bus.mem_wdata = wdata_full[2*XLEN-1:XLEN];
        bus.dmem_we   = (is_store && dm_hit) ? lane_full[2*NLANES-1:NLANES] : '0;
        bus.imem_we   = im_hit ? lane_full[2*NLANES-1:NLANES] : '0;
        hold_en       = is_load;
        lv_next       = is_load;
        src_next      = SRC_SPLIT;
        state_next    = ST_IDLE;
      end

      ST_IO_WAIT: begin
        bus.io_valid = 1'b1;
        bus.io_we    = is_store ? lane_full[NLANES-1:0] : '0;
        if (bus.io_ready) begin
          lv_next    = is_load;
          src_next   = SRC_IO;
          io_cap_en  = 1'b1;
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end else if (io_expire) begin
          timeout_next = 1'b1;
          lv_next      = is_load;
          state_next   = ST_IDLE;
          cnt_next     = 8'd0;
        end else begin
          req_ready = 1'b0;
          cnt_next  = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
      end
    endcase

    // Nothing may be written or requested while reset is held.
    if (!rst_n) begin
      bus.dmem_we  = '0;
      bus.imem_we  = '0;
      bus.io_valid = 1'b0;
      bus.io_we    = '0;
    end
  end

  // ---------------------------------------------------------------- load path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_valid_reg <= 1'b0;
      fault_reg      <= 1'b0;
      timeout_reg    <= 1'b0;
      ld_src_reg     <= SRC_ZERO;
      ld_off_reg     <= '0;
      ld_nbytes_reg  <= 4'd0;
      ld_zext_reg    <= 1'b0;
      io_cap_reg     <= '0;
      hold_reg       <= '0;
    end else begin
      load_valid_reg <= lv_next;
      fault_reg      <= fault_next;
      timeout_reg    <= timeout_next;
      if (lv_next) begin
        ld_src_reg    <= src_next;
        ld_off_reg    <= off;
        ld_nbytes_reg <= nbytes;
        ld_zext_reg   <= funct3[2];
      end
      if (io_cap_en) io_cap_reg <= bus.io_rdata;
      if (hold_en)   hold_reg   <= bus.dmem_rdata;
    end
  end

  // Split loads see {beat-1 word, beat-0 word}; everything else sees a single
  // word in the low half. Shifting by the offset lines the first byte up at
  // lane 0 in every case.
  logic [XLEN-1:0] ld_lower, ld_upper, ld_low, ld_left, ld_ext;
  logic [7:0]      ld_shamt;

  always_comb begin
    ld_lower = '0;
    ld_upper = '0;
    case (ld_src_reg)
      SRC_DMEM:  ld_lower = bus.dmem_rdata;
      SRC_IO:    ld_lower = io_cap_reg;
      SRC_SPLIT: begin
        ld_lower = hold_reg;
        ld_upper = bus.dmem_rdata;
      end
      default:   ld_lower = '0;
    endcase
  end

  assign ld_low   = XLEN'({ld_upper, ld_lower} >> {ld_off_reg, 3'b000});
  // Push the selected bytes to the top, then shift back down to extend.
  assign ld_shamt = 8'(XLEN) - 8'({ld_nbytes_reg, 3'b000});
  assign ld_left  = ld_low << ld_shamt;
  assign ld_ext   = ld_zext_reg ? (ld_left >> ld_shamt)
                                : XLEN'($signed(ld_left) >>> ld_shamt);

  assign load_valid     = load_valid_reg;
  assign load_data      = load_valid_reg ? ld_ext : '0;
  assign misalign_fault = fault_reg;
  assign io_timeout     = timeout_reg;
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Parametrised memory-stage access controller for the RISC-V core. It sits between the execute/memory pipeline register and the data memory, instruction memory (write path) and memory-mapped IO. It generates per-lane write enables and lane-aligned write data, decodes the target region, and extracts and extends load data. Unlike the earlier combinational controller, it handles misaligned accesses that cross a word as a two-beat sequence, and it runs IO accesses through a valid/ready handshake with stall and timeout.

## Interface
Parameters:
- XLEN, 32: datapath width; 32 or 64. NLANES = XLEN/8.
- ALLOW_MISALIGNED, 1: 1 splits word-crossing accesses into two beats; 0 faults on them.
- IO_WAIT_MAX, 15: maximum cycles `io_valid` is held before timeout (1..255).

Ports (reset is asynchronous, active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  memory-stage instruction present
- opcode  in  7  instruction opcode; LOAD=7'b0000011, STORE=7'b0100011
- funct3  in  3  size and signedness
- addr  in  XLEN  byte address
- wdata  in  XLEN  store data (rs2), right-justified
- req_ready  out  1  access completes this cycle; 0 stalls the pipeline
- mem_addr  out  XLEN  lane-aligned address to dmem/imem
- mem_wdata  out  XLEN  lane-shifted store data (shared by dmem, imem, io)
- dmem_we  out  NLANES  dmem lane write enables
- imem_we  out  NLANES  imem lane write enables
- dmem_rdata  in  XLEN  dmem read data, valid one cycle after mem_addr
- io_valid  out  1  IO request
- io_we  out  NLANES  IO lane write enables; 0 = read
- io_ready  in  1  IO accepts/completes request
- io_rdata  in  XLEN  IO read data, valid when io_ready=1
- load_data  out  XLEN  extracted and extended load result
- load_valid  out  1  load_data valid (one-cycle pulse)
- misalign_fault  out  1  one-cycle pulse; misaligned access rejected
- io_timeout  out  1  one-cycle pulse; IO handshake expired

## Operation
- Region decode uses addr[31:28]:
  - IO when addr[31:28]=4'b1000.
  - dmem when addr[31]=0 and addr[28]=1.
  - imem when addr[31]=0 and addr[29]=1; stores only.
  - dmem and imem may both match; both enables assert.
  - No match: store is dropped; load returns 0 with load_valid.
- Size from funct3[1:0]: 1, 2, 4 or 8 bytes. Size 8 is legal only when XLEN=64; otherwise the access is treated as a 4-byte access.
- funct3[2]=1 selects zero extension; 0 selects sign extension.
- Offset: off = addr mod NLANES. An access crosses when off+size > NLANES.
- Store lanes: lanes off..off+size-1 are enabled; mem_wdata = wdata << 8·off.
- Load extraction: take the size bytes starting at lane off of the returned word, then extend to XLEN.
- Crossing access, ALLOW_MISALIGNED=1 (dmem/imem only):
  - Beat 0 at the aligned address: lanes off..NLANES-1.
  - Beat 1 at the aligned address + NLANES: lanes 0..off+size-NLANES-1; mem_wdata = wdata >> 8·(NLANES-off).
  - For loads, beat-0 bytes are held in a register and merged with beat-1 bytes.
- Crossing access with ALLOW_MISALIGNED=0, or any crossing IO access: no enables, no io_valid, misalign_fault=1, req_ready=1.
- FSM states:
  - IDLE → SPLIT on an accepted crossing dmem/imem access.
  - IDLE → IO_WAIT on an IO access.
  - SPLIT → IDLE after beat 1.
  - IO_WAIT → IDLE on io_ready=1 or on timeout.
- Outputs when req_valid=0 or opcode is neither LOAD nor STORE: all enables 0, req_ready=1.

## Timing
- Reset: state IDLE; wait counter 0; hold register 0. All registered outputs 0: load_valid, load_data, misalign_fault, io_timeout. Enables, io_valid and io_we are 0 while rst_n=0. Reset mid-SPLIT or mid-IO_WAIT abandons the access with no further write.
- Aligned dmem/imem store: enables asserted in the same cycle as req_valid; req_ready=1.
- Aligned load: req_ready=1; load_valid and load_data the following cycle, from the registered funct3 and offset applied to dmem_rdata.
  - Back-to-back loads are pipelined: one result per cycle.
- Crossing access: 2 cycles.
  - Beat 0: req_ready=0.
  - Beat 1: req_ready=1.
  - Load result appears the cycle after beat 1.
- IO_WAIT:
  - io_valid, io_we and mem_addr are held stable and req_ready=0 until io_ready=1.
  - The handshake cycle has req_ready=1. For loads, load_valid follows one cycle later with data extracted from io_rdata captured at the handshake.
- Timeout: if io_ready is still 0 after IO_WAIT_MAX cycles with io_valid high:
  - io_valid drops.
  - io_timeout pulses.
  - req_ready=1.
  - A load returns 0 with load_valid.
- io_ready=1 on the same cycle as the counter expires counts as a handshake, not a timeout.
- The inputs are required to stay stable while req_ready=0.

## Test plan
- XLEN=32, SB to 0x1000_0003 with wdata=0x0000_00A5 → dmem_we=4'b1000, mem_wdata=0xA500_0000, req_ready=1.
- LH from 0x1000_0002, dmem word 0x8001_1234 → one cycle later load_data=0xFFFF_8001, load_valid=1. The same access as LHU → 0x0000_8001.
- ALLOW_MISALIGNED=1, SW to 0x1000_0006 with wdata=0xDDCC_BBAA:
  - Beat 0: mem_addr=0x1000_0004, we=4'b1100, mem_wdata=0xBBAA_0000, req_ready=0.
  - Beat 1: mem_addr=0x1000_0008, we=4'b0011, mem_wdata=0x0000_DDCC, req_ready=1.
- ALLOW_MISALIGNED=0, LW from 0x1000_0001 → misalign_fault pulse, no load_valid, no enables.
- IO LW from 0x8000_0004 with io_ready asserted on the 3rd wait cycle and io_rdata=0x1234_5678 → req_ready low for 2 cycles, then load_data=0x1234_5678. With io_ready held 0 and IO_WAIT_MAX=15 → io_timeout after 15 cycles and load_data=0.
- Store to 0x3000_0000 → dmem_we and imem_we both 4'b1111. Assert rst_n=0 during beat 0 of a crossing store → no beat-1 write; all outputs 0.
